lfsr_prng: RTL

- Parametrised Fibonacci LFSR pseudo-random source for the neural-network datapath (weight init, dropout masks, stochastic rounding).
- Generalises the fixed 8-bit generator to:
  - configurable width and polynomial
  - run-time seed load
  - parallel or bit-serial word assembly
- Output uses a valid/ready handshake with a one-entry output register, plus lock-up recovery and an accepted-word counter.

---
 rtl/lfsr_prng_pkg.sv | 17 +
 rtl/lfsr_prng_core.sv | 40 ++++
 rtl/lfsr_prng.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lfsr_prng_pkg.sv
// Shared definitions for the LFSR pseudo-random source: word assembly mode
// encoding and the Fibonacci feedback (parity of tapped state bits).
package lfsr_prng_pkg;

   localparam int MAX_WIDTH = 64;

   typedef enum logic {
      MODE_PAR = 1'b0,
      MODE_SER = 1'b1
   } mode_e;

   function automatic logic lfsr_feedback(input logic [MAX_WIDTH-1:0] state,
                                          input logic [MAX_WIDTH-1:0] poly);
      return ^(state & poly);
   endfunction

endpackage

// File: rtl/lfsr_prng_core.sv
// Fibonacci LFSR register with seed load and automatic recovery from the
// all-zero lock-up state (sticky lockup_err until the next seed load).
module lfsr_core
   import lfsr_prng_pkg::*;
#(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] POLY         = 16'hD008,
   parameter logic [WIDTH-1:0] SEED_DEFAULT = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] state,
   output logic             fb,
   output logic             zero,
   output logic             lockup_err
);

   assign fb   = lfsr_feedback(MAX_WIDTH'(state), MAX_WIDTH'(POLY));
   assign zero = (state == '0);

   // Seed load beats lock-up recovery, which beats a normal shift step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SEED_DEFAULT;
         lockup_err <= 1'b0;
      end else if (load) begin
         state      <= (load_value == '0) ? SEED_DEFAULT : load_value;
         lockup_err <= 1'b0;
      end else if (zero) begin
         state      <= SEED_DEFAULT;
         lockup_err <= 1'b1;
      end else if (step) begin
         state <= {state[WIDTH-2:0], fb};
      end
   end

endmodule

// File: rtl/lfsr_prng.sv
// Pseudo-random word source: LFSR core plus parallel/serial word assembly,
// a one-entry valid/ready output register and an accepted-word counter.
module lfsr_prng
   import lfsr_prng_pkg::*;
#(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] POLY         = 16'hD008,
   parameter int               OUT_W        = 32,
   parameter logic [WIDTH-1:0] SEED_DEFAULT = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [31:0]      word_count,
   output logic             lockup_err
);

   localparam int               CNT_W    = $clog2(OUT_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_W - 1);

   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] state_next;
   logic             fb;
   logic             zero;
   logic             slot_free;
   logic             adv;
   logic             word_done;
   logic [CNT_W-1:0] bit_cnt;
   logic [OUT_W-2:0] shift_reg;
   logic [OUT_W-1:0] ser_word;
   logic [OUT_W-1:0] par_word;
   mode_e            active_mode;
   mode_e            cur_mode;

   lfsr_core #(
      .WIDTH       (WIDTH),
      .POLY        (POLY),
      .SEED_DEFAULT(SEED_DEFAULT)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (adv),
      .load      (seed_load),
      .load_value(seed_data),
      .state     (state),
      .fb        (fb),
      .zero      (zero),
      .lockup_err(lockup_err)
   );

   assign state_next = {state[WIDTH-2:0], fb};
   assign slot_free  = ~out_valid | out_ready;
   assign adv        = en & slot_free & ~seed_load & ~zero;
   assign cur_mode   = (bit_cnt == '0) ? mode_e'(mode) : active_mode;
   assign ser_word   = {shift_reg, fb};
   assign word_done  = adv & ((cur_mode == MODE_PAR) | (bit_cnt == LAST_BIT));

   if (OUT_W > WIDTH) begin : g_zext
      assign par_word = {{(OUT_W - WIDTH){1'b0}}, state_next};
   end else if (OUT_W == WIDTH) begin : g_same
      assign par_word = state_next;
   end else begin : g_trunc
      assign par_word = state_next[OUT_W-1:0];
   end

   // Mode only takes effect on a word boundary; mid-word it is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_mode <= MODE_PAR;
      end else begin
         active_mode <= cur_mode;
      end
   end

   // Serial assembly: feedback bits enter at the LSB, first bit ends up as MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (seed_load) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (adv && cur_mode == MODE_SER) begin
         if (bit_cnt == LAST_BIT) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
         end else begin
            bit_cnt   <= bit_cnt + CNT_W'(1);
            shift_reg <= ser_word[OUT_W-2:0];
         end
      end
   end

   // One-entry output register; a new word may replace one accepted this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (seed_load) begin
         out_valid <= 1'b0;
      end else if (word_done) begin
         out_valid <= 1'b1;
         out_data  <= (cur_mode == MODE_PAR) ? par_word : ser_word;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Count every accepted word; a seed load cycle discards rather than accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_count <= '0;
      end else if (out_valid && out_ready && !seed_load) begin
         word_count <= word_count + 32'd1;
      end
   end

endmodule
